// File: rtl/cam_capture_fmt.sv
// OV camera 2-byte/pixel stream -> formatted, optionally decimated frame-buffer writes.
// Write strobe one pclk after a pixel's second byte; no backpressure, the RAM port always accepts.
module cam_capture_fmt #(
  parameter int AW    = 15,
  parameter int DW    = 12,
  parameter int IMG_W = 160,
  parameter int IMG_H = 120
) (
  input  logic          CAM_pclk,
  input  logic          rst,
  input  logic          CAM_vsync,
  input  logic          CAM_href,
  input  logic [7:0]    CAM_px_data,
  input  logic          capture_en,
  input  logic [1:0]    fmt_sel,
  input  logic [1:0]    dec_sel,
  output logic          DP_RAM_regW,
  output logic [AW-1:0] DP_RAM_addr_in,
  output logic [DW-1:0] DP_RAM_data_in,
  output logic          frame_done,
  output logic [7:0]    frame_cnt,
  output logic          line_err
);

  typedef enum logic [2:0] {IDLE, VS, WAIT, BYTE1, BYTE2} state_t;

  localparam int CW   = $clog2(IMG_W + 1);
  localparam int RW   = $clog2(IMG_H + 1);
  localparam int LIM0 = IMG_W * IMG_H - 1;
  localparam int LIM1 = (IMG_W >> 1) * (IMG_H >> 1) - 1;
  localparam int LIM2 = (IMG_W >> 2) * (IMG_H >> 2) - 1;
  localparam logic [CW-1:0] W_END = CW'(IMG_W);
  localparam logic [RW-1:0] H_END = RW'(IMG_H);

  state_t        state;
  logic          cap_sh;
  logic [1:0]    fmt_sh;
  logic [1:0]    dec_sh;
  logic [7:0]    b1;
  logic [7:0]    b2;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          pend;
  logic          frame_wr;

  logic [1:0]    d;
  logic          dec_ok;
  logic          keep;
  logic [31:0]   lim;
  logic          addr_ok;
  logic          issue;
  logic          vs_rise;
  logic [DW-1:0] px;

  assign d = (dec_sh == 2'd3) ? 2'd2 : dec_sh;

  always_comb begin
    case (d)
      2'd0:    dec_ok = 1'b1;
      2'd1:    dec_ok = !col[0] && !row[0];
      default: dec_ok = (col[1:0] == 2'b00) && (row[1:0] == 2'b00);
    endcase
  end

  // col/row saturate at the image size, so the bound test also rejects overlong lines/frames
  assign keep = dec_ok && (col < W_END) && (row < H_END);

  always_comb begin
    case (d)
      2'd0:    lim = LIM0;
      2'd1:    lim = LIM1;
      default: lim = LIM2;
    endcase
  end

  assign addr_ok = 32'(DP_RAM_addr_in) <= lim;
  assign issue   = pend && addr_ok;
  assign vs_rise = CAM_vsync && (state != IDLE) && (state != VS);

  always_comb begin
    case (fmt_sh)
      2'd0:    px = DW'({b1[3:0], b2});
      2'd1:    px = DW'({b1[7:4], b1[2:0], b2[7], b2[4:1]});
      2'd2:    px = DW'({b1[7:5], b1[2:0], b2[4:3]});
      default: px = DW'({b1[7:4], b1[7:4], b1[7:4]});
    endcase
  end

  always_ff @(posedge CAM_pclk) begin
    if (rst) begin
      state          <= IDLE;
      cap_sh         <= 1'b0;
      fmt_sh         <= 2'd0;
      dec_sh         <= 2'd0;
      b1             <= 8'd0;
      b2             <= 8'd0;
      col            <= '0;
      row            <= '0;
      pend           <= 1'b0;
      frame_wr       <= 1'b0;
      DP_RAM_regW    <= 1'b0;
      DP_RAM_addr_in <= '0;
      DP_RAM_data_in <= '0;
      frame_done     <= 1'b0;
      frame_cnt      <= 8'd0;
      line_err       <= 1'b0;
    end else begin
      DP_RAM_regW <= issue;
      frame_done  <= 1'b0;
      pend        <= 1'b0;
      if (issue) begin
        DP_RAM_data_in <= px;
        frame_wr       <= 1'b1;
      end
      if (pend && !addr_ok)
        line_err <= 1'b1;
      if (DP_RAM_regW)
        DP_RAM_addr_in <= DP_RAM_addr_in + 1'b1;

      // A pixel completed on the previous edge still counts toward this frame's done pulse
      if (vs_rise) begin
        state <= VS;
        if (frame_wr || issue) begin
          frame_done <= 1'b1;
          frame_cnt  <= frame_cnt + 8'd1;
        end
      end else begin
        case (state)
          IDLE: if (CAM_vsync) state <= VS;
          VS: begin
            cap_sh         <= capture_en;
            fmt_sh         <= fmt_sel;
            dec_sh         <= dec_sel;
            DP_RAM_addr_in <= '0;
            row            <= '0;
            col            <= '0;
            line_err       <= 1'b0;
            frame_wr       <= 1'b0;
            if (!CAM_vsync) state <= WAIT;
          end
          WAIT: begin
            if (CAM_href && cap_sh) begin
              b1    <= CAM_px_data;
              state <= BYTE1;
            end
          end
          BYTE1: begin
            if (CAM_href) begin
              b2    <= CAM_px_data;
              pend  <= keep;
              if (col < W_END) col <= col + 1'b1;
              state <= BYTE2;
            end else begin
              line_err <= 1'b1;
              col      <= '0;
              if ((col != '0) && (row < H_END)) row <= row + 1'b1;
              state    <= WAIT;
            end
          end
          BYTE2: begin
            if (CAM_href) begin
              b1    <= CAM_px_data;
              state <= BYTE1;
            end else begin
              col   <= '0;
              if ((col != '0) && (row < H_END)) row <= row + 1'b1;
              state <= WAIT;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cam_capture_fmt.sv
// Directed bench for cam_capture_fmt on a reduced 16x12 image.
module tb_cam_capture_fmt;
  localparam int AW = 15;
  localparam int DW = 12;
  localparam int W  = 16;
  localparam int H  = 12;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          vsync = 1'b0;
  logic          href  = 1'b0;
  logic [7:0]    px    = 8'd0;
  logic          cap   = 1'b0;
  logic [1:0]    fmt   = 2'd0;
  logic [1:0]    dec   = 2'd0;
  logic          regw;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic          fdone;
  logic [7:0]    fcnt;
  logic          lerr;

  always #5 clk = ~clk;

  cam_capture_fmt #(.AW(AW), .DW(DW), .IMG_W(W), .IMG_H(H)) dut (
    .CAM_pclk      (clk),
    .rst           (rst),
    .CAM_vsync     (vsync),
    .CAM_href      (href),
    .CAM_px_data   (px),
    .capture_en    (cap),
    .fmt_sel       (fmt),
    .dec_sel       (dec),
    .DP_RAM_regW   (regw),
    .DP_RAM_addr_in(addr),
    .DP_RAM_data_in(data),
    .frame_done    (fdone),
    .frame_cnt     (fcnt),
    .line_err      (lerr)
  );

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0, addr_bad = 0, data_bad = 0, dbl = 0, gap2 = 0, fd_cnt = 0;
  int cyc = 0, last_wr = 0;
  int exp_mode = 0, exp_d = 0, exp_fcnt = 0;
  logic [7:0]    b1c = 8'd0;
  logic [7:0]    b2c = 8'd0;
  logic [DW-1:0] exp_const = '0;
  logic          le_end = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pattern mode: camera sends b1=row, b2=col, so fmt0 words are {row[3:0], col}
  function automatic logic [DW-1:0] exp_word(input int k);
    int pw, r, c;
    logic [7:0] rb, cb;
    if (exp_mode == 1) return exp_const;
    pw = W >> exp_d;
    r  = (k / pw) << exp_d;
    c  = (k % pw) << exp_d;
    rb = 8'(r);
    cb = 8'(c);
    return DW'({rb[3:0], cb});
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (fdone) fd_cnt++;
      if (regw) begin
        if (addr !== AW'(wr_cnt)) addr_bad++;
        if (data !== exp_word(wr_cnt)) data_bad++;
        if (wr_cnt > 0 && cyc - last_wr == 1) dbl++;
        if (wr_cnt > 0 && cyc - last_wr == 2) gap2++;
        last_wr = cyc;
        wr_cnt++;
      end
    end
  endtask

  task automatic start_frame(input logic [1:0] f, input logic [1:0] d, input logic c, input int mode);
    fmt = f; dec = d; cap = c; exp_mode = mode;
    exp_d = (d == 2'd3) ? 2 : int'(d);
    vsync = 1'b1; tick(4);
    vsync = 1'b0; tick(3);
    wr_cnt = 0; addr_bad = 0; data_bad = 0; dbl = 0; gap2 = 0; fd_cnt = 0;
  endtask

  task automatic end_frame();
    le_end = lerr;
    vsync = 1'b1; tick(3);
  endtask

  task automatic send_line(input int nbytes, input int row, input int rst_at);
    href = 1'b1;
    for (int i = 0; i < nbytes; i++) begin
      if (exp_mode == 1) px = (i % 2 == 0) ? b1c : b2c;
      else px = (i % 2 == 0) ? 8'(row) : 8'(i / 2);
      if (i == rst_at) rst = 1'b1;
      tick(1);
      if (i == rst_at) begin
        rst = 1'b0;
        chk("midrst_regW", 32'(regw), 0);
        chk("midrst_addr", 32'(addr), 0);
        chk("midrst_data", 32'(data), 0);
        chk("midrst_frame_done", 32'(fdone), 0);
        chk("midrst_frame_cnt", 32'(fcnt), 0);
        chk("midrst_line_err", 32'(lerr), 0);
        wr_cnt = 0;
        exp_fcnt = 0;
      end
    end
    href = 1'b0; px = 8'd0;
    tick(4);
  endtask

  task automatic frame_check(input string tag, input int exp_wr, input int exp_fd);
    chk({tag, "_writes"}, wr_cnt, exp_wr);
    chk({tag, "_addr_seq_errs"}, addr_bad, 0);
    chk({tag, "_data_errs"}, data_bad, 0);
    chk({tag, "_frame_done"}, fd_cnt, exp_fd);
    chk({tag, "_frame_cnt"}, 32'(fcnt), exp_fcnt);
  endtask

  initial begin
    tick(3);
    chk("rst_regW", 32'(regw), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_data", 32'(data), 0);
    chk("rst_frame_done", 32'(fdone), 0);
    chk("rst_frame_cnt", 32'(fcnt), 0);
    chk("rst_line_err", 32'(lerr), 0);
    rst = 1'b0;
    tick(2);

    // Full frame, fmt0, no decimation
    start_frame(2'd0, 2'd0, 1'b1, 0);
    for (int r = 0; r < H; r++) send_line(2 * W, r, -1);
    end_frame();
    exp_fcnt = 1;
    frame_check("full", W * H, 1);
    chk("full_b2b_gaps", gap2, (W - 1) * H);
    chk("full_double_strobe", dbl, 0);
    chk("full_line_err", 32'(le_end), 0);

    // Write latency, then end-of-line coinciding with vsync rise
    start_frame(2'd0, 2'd0, 1'b1, 1);
    exp_const = 12'hABC;
    href = 1'b1; px = 8'h0A; tick(1);
    px = 8'hBC; tick(1);
    chk("lat_n_regW", 32'(regw), 0);
    px = 8'h0A; tick(1);
    chk("lat_n1_regW", 32'(regw), 1);
    chk("lat_n1_addr", 32'(addr), 0);
    chk("lat_n1_data", 32'(data), 32'h0ABC);
    px = 8'hBC; tick(1);
    chk("lat_n2_regW", 32'(regw), 0);
    chk("lat_n2_addr", 32'(addr), 1);
    href = 1'b0; vsync = 1'b1; tick(1);
    chk("eolvs_regW", 32'(regw), 1);
    chk("eolvs_addr", 32'(addr), 1);
    chk("eolvs_frame_done", 32'(fdone), 1);
    tick(1);
    chk("eolvs_done_pulse", 32'(fdone), 0);
    exp_fcnt = 2;
    frame_check("eolvs", 2, 1);

    // Format conversions, two pixels each
    start_frame(2'd1, 2'd0, 1'b1, 1);
    b1c = 8'hF8; b2c = 8'h1F; exp_const = 12'hF0F;
    send_line(4, 0, -1); end_frame(); exp_fcnt++;
    frame_check("fmt1", 2, 1);
    start_frame(2'd2, 2'd0, 1'b1, 1);
    exp_const = 12'h0E3;
    send_line(4, 0, -1); end_frame(); exp_fcnt++;
    frame_check("fmt2", 2, 1);
    start_frame(2'd3, 2'd0, 1'b1, 1);
    b1c = 8'h9C; b2c = 8'h55; exp_const = 12'h999;
    send_line(4, 0, -1); end_frame(); exp_fcnt++;
    frame_check("fmt3", 2, 1);

    // Decimation /2 and code 3 (same as /4)
    start_frame(2'd0, 2'd1, 1'b1, 0);
    for (int r = 0; r < H; r++) send_line(2 * W, r, -1);
    end_frame(); exp_fcnt++;
    frame_check("dec2", (W / 2) * (H / 2), 1);
    start_frame(2'd0, 2'd3, 1'b1, 0);
    for (int r = 0; r < H; r++) send_line(2 * W, r, -1);
    end_frame(); exp_fcnt++;
    frame_check("dec4", (W / 4) * (H / 4), 1);

    // Odd byte count line, then a clean frame
    start_frame(2'd0, 2'd0, 1'b1, 0);
    send_line(2 * W + 1, 0, -1);
    end_frame(); exp_fcnt++;
    frame_check("odd", W, 1);
    chk("odd_line_err", 32'(le_end), 1);
    start_frame(2'd0, 2'd0, 1'b1, 0);
    send_line(2 * W, 0, -1);
    end_frame(); exp_fcnt++;
    frame_check("after_odd", W, 1);
    chk("after_odd_line_err", 32'(le_end), 0);

    // Capture disabled at vsync; enabling mid-frame must not take effect
    start_frame(2'd0, 2'd0, 1'b0, 0);
    cap = 1'b1;
    for (int r = 0; r < H; r++) send_line(2 * W, r, -1);
    end_frame();
    frame_check("cap_off", 0, 0);
    // Re-enabled; fmt change mid-frame must not take effect
    start_frame(2'd0, 2'd0, 1'b1, 0);
    fmt = 2'd3;
    send_line(2 * W, 0, -1);
    end_frame(); exp_fcnt++;
    frame_check("cap_on", W, 1);

    // Reset in the middle of line 5, then a full frame from address 0
    start_frame(2'd0, 2'd0, 1'b1, 0);
    for (int r = 0; r < H; r++) send_line(2 * W, r, (r == 5) ? 17 : -1);
    end_frame();
    frame_check("rst_frame", 0, 0);
    start_frame(2'd0, 2'd0, 1'b1, 0);
    for (int r = 0; r < H; r++) send_line(2 * W, r, -1);
    end_frame(); exp_fcnt = 1;
    frame_check("post_rst", W * H, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
